// File: rtl/xyz_to_cct_converter_if.sv
// Request/result bus of the XYZ -> CCT converter.
// The master drives a packed Q16.16 XYZ triple; the slave returns a clamped
// Kelvin value, an error flag and a busy indication.
interface xyz_to_cct_converter_if;
  logic [95:0] xyz_in;     // [31:0]=X, [63:32]=Y, [95:64]=Z, unsigned Q16.16
  logic        xyz_valid;
  logic [15:0] cct_out;
  logic        cct_valid;
  logic        cct_err;
  logic        busy;

  modport master (output xyz_in, xyz_valid, input cct_out, cct_valid, cct_err, busy);
  modport slave  (input xyz_in, xyz_valid, output cct_out, cct_valid, cct_err, busy);
endinterface

// File: rtl/xyz_to_cct_converter.sv
// XYZ tristimulus -> correlated colour temperature using McCamy's cubic.
// Fully serial: two 16-step restoring dividers for chromaticity x/y, one
// 20-step restoring divider for n, then three Horner steps. Fixed 58-cycle
// job; result and status are registered and pulse for one cycle afterwards.
module xyz_to_cct_converter #(
  parameter logic [15:0] CCT_MIN = 16'd3000,
  parameter logic [15:0] CCT_MAX = 16'd8000
) (
  input logic                    clk,
  input logic                    rst_n,
  xyz_to_cct_converter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_DIV_X, S_DIV_Y, S_PREP_N, S_DIV_N, S_POLY, S_OUT
  } state_e;

  localparam logic signed [17:0] X_EPI = 18'sd21758;     // 0.3320 in Q0.16
  localparam logic signed [17:0] Y_EPI = 18'sd12177;     // 0.1858 in Q0.16
  localparam logic signed [63:0] A3 = 64'sd29425664;     // 449    << 16
  localparam logic signed [63:0] A2 = 64'sd231014400;    // 3525   << 16
  localparam logic signed [63:0] A1 = 64'sd447171789;    // 6823.3
  localparam logic signed [63:0] A0 = 64'sd361780347;    // 5520.33
  localparam logic signed [63:0] K_MIN = {48'd0, CCT_MIN};
  localparam logic signed [63:0] K_MAX = {48'd0, CCT_MAX};

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [95:0]        xyz_q, xyz_d;
  logic [33:0]        s_q, s_d;          // X+Y+Z
  logic [33:0]        rem_q, rem_d;      // shared partial remainder
  logic [19:0]        quo_q, quo_d;      // shared quotient shift register
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic [16:0]        den_abs_q, den_abs_d;
  logic [19:0]        nsh_q, nsh_d;      // low dividend bits of |num|<<16
  logic               n_neg_q, n_neg_d, n_ovf_q, n_ovf_d;
  logic signed [20:0] n_q, n_d;
  logic signed [63:0] acc_q, acc_d;
  logic               err_q, err_d;
  logic [15:0]        cct_out_q, cct_out_d;
  logic               cct_valid_q, cct_valid_d, cct_err_q, cct_err_d, busy_q, busy_d;

  // Combinational helpers shared by the datapath.
  logic [34:0]        divisor, rem_sh;
  logic               rem_ge;
  logic [33:0]        rem_nx;
  logic [19:0]        quo_nx, n_mag;
  logic signed [17:0] num_c, den_c;
  logic [16:0]        num_abs, den_abs;
  logic signed [63:0] n_ext, prod, coef, acc_step, k;

  // Next-state and step counter of the job sequencer.
  // NOTE: every combinational output gets a default first so no path can hold a stale value (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (bus.xyz_valid) state_d = S_SUM;
      S_SUM:    begin state_d = S_DIV_X; cnt_d = 5'd15; end
      S_DIV_X:  if (cnt_q == 5'd0) begin state_d = S_DIV_Y; cnt_d = 5'd15; end
                else cnt_d = cnt_q - 5'd1;
      S_DIV_Y:  if (cnt_q == 5'd0) state_d = S_PREP_N;
                else cnt_d = cnt_q - 5'd1;
      S_PREP_N: begin state_d = S_DIV_N; cnt_d = 5'd19; end
      S_DIV_N:  if (cnt_q == 5'd0) begin state_d = S_POLY; cnt_d = 5'd2; end
                else cnt_d = cnt_q - 5'd1;
      S_POLY:   if (cnt_q == 5'd0) state_d = S_OUT;
                else cnt_d = cnt_q - 5'd1;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // busy also covers the result cycle that follows OUT
    busy_d = (state_d != S_IDLE) || (state_q == S_OUT);
  end

  // Divider step, operand preparation, Horner step and output rounding.
  always_comb begin
    divisor  = (state_q == S_DIV_N) ? {18'd0, den_abs_q} : {1'b0, s_q};
    rem_sh   = {rem_q, (state_q == S_DIV_N) ? nsh_q[19] : 1'b0};
    rem_ge   = rem_sh >= divisor;
    rem_nx   = rem_ge ? 34'(rem_sh - divisor) : rem_sh[33:0];
    quo_nx   = 20'({quo_q, rem_ge});

    num_c    = $signed({2'b00, x_q}) - X_EPI;
    den_c    = Y_EPI - $signed({2'b00, y_q});
    num_abs  = num_c[17] ? 17'(-num_c) : num_c[16:0];
    den_abs  = den_c[17] ? 17'(-den_c) : den_c[16:0];
    n_mag    = n_ovf_q ? 20'hFFFFF : quo_nx;

    n_ext    = 64'(n_q);
    prod     = acc_q * n_ext;
    coef     = (cnt_q == 5'd2) ? A2 : (cnt_q == 5'd1) ? A1 : A0;
    acc_step = (prod >>> 16) + coef;
    k        = (acc_q + 64'sd32768) >>> 16;
  end

  // Datapath register updates, sequenced by the current state.
  always_comb begin
    xyz_d = xyz_q;   s_d = s_q;     rem_d = rem_q;   quo_d = quo_q;
    x_d = x_q;       y_d = y_q;     den_abs_d = den_abs_q;
    nsh_d = nsh_q;   n_neg_d = n_neg_q;  n_ovf_d = n_ovf_q;
    n_d = n_q;       acc_d = acc_q; err_d = err_q;
    cct_out_d = cct_out_q;  cct_err_d = cct_err_q;  cct_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.xyz_valid) begin
        xyz_d = bus.xyz_in;
        err_d = 1'b0;
      end
      S_SUM: begin
        s_d   = {2'd0, xyz_q[31:0]} + {2'd0, xyz_q[63:32]} + {2'd0, xyz_q[95:64]};
        rem_d = {2'd0, xyz_q[31:0]};
        quo_d = '0;
        if (s_d == 34'd0) err_d = 1'b1;
      end
      S_DIV_X: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == 5'd0) begin
          x_d   = quo_nx[15:0];   // X==S yields all ones, i.e. saturated 1.0
          rem_d = {2'd0, xyz_q[63:32]};
          quo_d = '0;
        end
      end
      S_DIV_Y: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == 5'd0) y_d = quo_nx[15:0];
      end
      S_PREP_N: begin
        den_abs_d = den_abs;
        // Partial remainder starts with the bits above the 20 quotient bits;
        // if that is already >= |den| the quotient cannot fit in Q4.16.
        rem_d     = {21'd0, num_abs[16:4]};
        nsh_d     = {num_abs[3:0], 16'd0};
        quo_d     = '0;
        n_neg_d   = num_c[17] ^ den_c[17];
        n_ovf_d   = {4'd0, num_abs} >= {den_abs, 4'd0};
        if (den_c == 18'sd0) err_d = 1'b1;
      end
      S_DIV_N: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        nsh_d = nsh_q << 1;
        if (cnt_q == 5'd0) begin
          n_d   = n_neg_q ? -$signed({1'b0, n_mag}) : $signed({1'b0, n_mag});
          acc_d = A3;
        end
      end
      S_POLY: acc_d = acc_step;
      S_OUT: begin
        cct_valid_d = 1'b1;
        cct_err_d   = err_q;
        if (err_q)           cct_out_d = CCT_MAX;
        else if (k < K_MIN)  cct_out_d = CCT_MIN;
        else if (k > K_MAX)  cct_out_d = CCT_MAX;
        else                 cct_out_d = k[15:0];
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: datapath registers are reset too, so an aborted job leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q <= '0;      xyz_q <= '0;    s_q <= '0;
      rem_q <= '0;        quo_q <= '0;      x_q <= '0;      y_q <= '0;
      den_abs_q <= '0;    nsh_q <= '0;      n_neg_q <= 1'b0; n_ovf_q <= 1'b0;
      n_q <= '0;          acc_q <= '0;      err_q <= 1'b0;
      cct_out_q <= '0;    cct_valid_q <= 1'b0; cct_err_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;   xyz_q <= xyz_d; s_q <= s_d;
      rem_q <= rem_d;     quo_q <= quo_d;   x_q <= x_d;     y_q <= y_d;
      den_abs_q <= den_abs_d; nsh_q <= nsh_d; n_neg_q <= n_neg_d; n_ovf_q <= n_ovf_d;
      n_q <= n_d;         acc_q <= acc_d;   err_q <= err_d;
      cct_out_q <= cct_out_d; cct_valid_q <= cct_valid_d; cct_err_q <= cct_err_d;
      busy_q <= busy_d;
    end
  end

  assign bus.cct_out   = cct_out_q;
  assign bus.cct_valid = cct_valid_q;
  assign bus.cct_err   = cct_err_q;
  assign bus.busy      = busy_q;

endmodule
